// File: rtl/decimal_entry.sv
// rtl/decimal_entry.sv - pushbutton 3-digit decimal entry with debounce and BCD-to-binary conversion
//
// Purpose: conditions four raw pushbuttons (2-flop sync + debounce + rising-edge
// event), keeps three BCD digits for display echo, and on Enter converts them to
// an 8-bit binary value through a short FSM, saturating at 255.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_inc    raw button: increment selected digit (9 wraps to 0)
//   btn_next   raw button: selection 2 -> 1 -> 0 -> 2
//   btn_enter  raw button: convert digits and publish value
//   btn_clear  raw button: zero all digits, selection back to hundreds
//   value      last converted value
//   valid      one-cycle pulse when value updates
//   overflow   last conversion saturated
//   busy       conversion in progress
//   digit_sel  selected digit (2 = hundreds, 1 = tens, 0 = units)
//   bcd2..0    hundreds, tens, units digits
module decimal_entry #(
  parameter int DB_COUNT = 1024,
  parameter int DB_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [7:0] value,
  output logic       valid,
  output logic       overflow,
  output logic       busy,
  output logic [1:0] digit_sel,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  localparam int B_INC   = 0;
  localparam int B_NEXT  = 1;
  localparam int B_ENTER = 2;
  localparam int B_CLEAR = 3;

  typedef enum logic [2:0] {IDLE, CONV_H, CONV_T, CONV_U, DONE} state_t;

  logic [3:0]      btn_raw;
  logic [3:0]      sync1_q, sync2_q, deb_q, ev_q;
  logic [DB_W-1:0] cnt_q [4];

  state_t     state_q;
  logic [9:0] acc_q;
  logic [9:0] sum_d;
  logic [7:0] value_q;
  logic       valid_q, overflow_q, busy_q;
  logic [1:0] sel_q;
  logic [3:0] bcd2_q, bcd1_q, bcd0_q;

  assign btn_raw = {btn_clear, btn_enter, btn_next, btn_inc};

  // Final accumulation step; computed here so value/valid can be registered on
  // the CONV_U -> DONE edge and valid is visible during the DONE cycle.
  assign sum_d = acc_q + {6'd0, bcd0_q};

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Input conditioning: a level must disagree with the debounced level for
  // DB_COUNT+1 consecutive cycles before it is accepted. The event pulse is
  // registered alongside the 0->1 flip of the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      ev_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_W'(DB_COUNT)) begin
          deb_q[i] <= sync2_q[i];
          ev_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Digit entry and conversion FSM. Events are only honoured in IDLE, so the
  // digits stay frozen for the whole conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= 2'd2;
      bcd2_q     <= '0;
      bcd1_q     <= '0;
      bcd0_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ev_q[B_CLEAR]) begin
            bcd2_q <= '0;
            bcd1_q <= '0;
            bcd0_q <= '0;
            sel_q  <= 2'd2;
          end else if (ev_q[B_ENTER]) begin
            state_q <= CONV_H;
            busy_q  <= 1'b1;
          end else if (ev_q[B_NEXT]) begin
            sel_q <= (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
          end else if (ev_q[B_INC]) begin
            case (sel_q)
              2'd2:    bcd2_q <= inc_digit(bcd2_q);
              2'd1:    bcd1_q <= inc_digit(bcd1_q);
              default: bcd0_q <= inc_digit(bcd0_q);
            endcase
          end
        end
        CONV_H: begin
          acc_q   <= {6'd0, bcd2_q} * 10'd100;
          state_q <= CONV_T;
        end
        CONV_T: begin
          acc_q   <= acc_q + {6'd0, bcd1_q} * 10'd10;
          state_q <= CONV_U;
        end
        CONV_U: begin
          acc_q <= sum_d;
          if (sum_d > 10'd255) begin
            value_q    <= 8'hFF;
            overflow_q <= 1'b1;
          end else begin
            value_q    <= sum_d[7:0];
            overflow_q <= 1'b0;
          end
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign digit_sel = sel_q;
  assign bcd2      = bcd2_q;
  assign bcd1      = bcd1_q;
  assign bcd0      = bcd0_q;

endmodule
